data_table_delete: RTL

- Executes DELETE tasks on the hash-table data RAM. It is the inverse of the insert engine.
- Walks the bucket chain starting at the head pointer and compares keys. On a match it unlinks the node, either by rewriting the head table or by patching the previous node's next_ptr.
- Returns the freed address to empty pointer storage and reports the result.
- Sits beside the insert/search engines behind the data-table task arbiter and shares the data RAM, head table and empty-pointer storage through that arbiter.

---
 rtl/data_table_delete.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/data_table_delete.sv
// Hash-table DELETE engine: walks a bucket chain in the data RAM, unlinks the
// matching node (head-table rewrite or predecessor patch) and frees its address.
package ht_pkg;
   localparam int KEY_WIDTH        = 8;
   localparam int VALUE_WIDTH      = 16;
   localparam int TABLE_ADDR_WIDTH = 4;
   localparam int BUCKET_WIDTH     = 3;

   typedef enum logic [1:0] {CMD_SEARCH, CMD_INSERT, CMD_DELETE} ht_cmd_t;

   typedef enum logic [2:0] {
      SEARCH_FOUND,
      SEARCH_NOT_SUCCESS_NO_ENTRY,
      INSERT_SUCCESS,
      INSERT_SUCCESS_SAME_KEY,
      INSERT_NOT_SUCCESS_TABLE_IS_FULL,
      DELETE_SUCCESS,
      DELETE_NOT_SUCCESS_NO_ENTRY
   } ht_res_t;

   typedef struct packed {
      logic [KEY_WIDTH-1:0]        key;
      logic [VALUE_WIDTH-1:0]      value;
      logic [TABLE_ADDR_WIDTH-1:0] next_ptr;
      logic                        next_ptr_val;
   } ram_data_t;

   typedef struct packed {
      logic [KEY_WIDTH-1:0]        key;
      logic [VALUE_WIDTH-1:0]      value;
      logic [BUCKET_WIDTH-1:0]     bucket;
      logic [TABLE_ADDR_WIDTH-1:0] head_ptr;
      logic                        head_ptr_val;
      ht_cmd_t                     cmd;
   } ht_data_task_t;

   typedef struct packed {
      logic [KEY_WIDTH-1:0]   key;
      logic [VALUE_WIDTH-1:0] value;
      ht_cmd_t                cmd;
      ht_res_t                res;
   } ht_result_t;
endpackage

module data_table_delete
   import ht_pkg::*;
#(
   parameter int RAM_LATENCY = 2,
   parameter int A_WIDTH     = TABLE_ADDR_WIDTH
)(
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  ht_data_task_t           task_i,
   input  logic                    task_valid_i,
   output logic                    task_ready_o,
   input  ram_data_t               rd_data_i,
   output logic [A_WIDTH-1:0]      rd_addr_o,
   output logic                    rd_en_o,
   output logic [A_WIDTH-1:0]      wr_addr_o,
   output ram_data_t               wr_data_o,
   output logic                    wr_en_o,
   output logic [A_WIDTH-1:0]      add_empty_ptr_o,
   output logic                    add_empty_ptr_en_o,
   output logic [BUCKET_WIDTH-1:0] head_wr_addr_o,
   output logic [A_WIDTH-1:0]      head_wr_data_ptr_o,
   output logic                    head_wr_data_ptr_val_o,
   output logic                    head_wr_en_o,
   output ht_result_t              result_o,
   output logic                    result_valid_o,
   input  logic                    result_ready_i
);

   typedef enum logic [2:0] {
      IDLE_S, READ_HEAD_S, GO_ON_CHAIN_S, IN_HEAD_S, IN_MIDDLE_S, DONE_S, NOT_FOUND_S
   } state_t;

   state_t               state, state_next;
   ht_data_task_t        task_locked;
   ram_data_t            cur_data, prev_data;
   logic [A_WIDTH-1:0]   cur_addr, prev_addr;
   logic                 rd_issued;
   logic [RAM_LATENCY-1:0] rd_pipe;
   logic                 rd_data_val, key_match, tail, task_accept, in_read;

   assign task_ready_o = (state == IDLE_S);
   assign task_accept  = task_valid_i && task_ready_o;
   assign in_read      = (state == READ_HEAD_S) || (state == GO_ON_CHAIN_S);
   // One read per visited node: rd_issued blocks re-issue until the data returns.
   assign rd_en_o      = in_read && !rd_issued;
   assign rd_addr_o    = cur_addr;
   assign rd_data_val  = rd_pipe[RAM_LATENCY-1];
   assign key_match    = (rd_data_i.key == task_locked.key);
   assign tail         = !rd_data_i.next_ptr_val;

   generate
      if (RAM_LATENCY == 1) begin : g_pipe_single
         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) rd_pipe <= '0;
            else          rd_pipe <= rd_en_o;
         end
      end else begin : g_pipe_multi
         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) rd_pipe <= '0;
            else          rd_pipe <= {rd_pipe[RAM_LATENCY-2:0], rd_en_o};
         end
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= IDLE_S;
      else          state <= state_next;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         task_locked <= '0;
         cur_addr    <= '0;
         cur_data    <= '0;
         prev_addr   <= '0;
         prev_data   <= '0;
         rd_issued   <= 1'b0;
      end else begin
         if (task_accept) begin
            task_locked <= task_i;
            if (task_i.head_ptr_val) cur_addr <= task_i.head_ptr;
         end
         if (rd_en_o)          rd_issued <= 1'b1;
         else if (rd_data_val) rd_issued <= 1'b0;
         if (in_read && rd_data_val) begin
            cur_data <= rd_data_i;
            if (!key_match && !tail) begin
               prev_addr <= cur_addr;
               prev_data <= rd_data_i;
               cur_addr  <= rd_data_i.next_ptr;
            end
         end
      end
   end

   always_comb begin
      state_next                = state;
      wr_en_o                   = 1'b0;
      wr_addr_o                 = prev_addr;
      wr_data_o                 = prev_data;
      wr_data_o.next_ptr        = cur_data.next_ptr;
      wr_data_o.next_ptr_val    = cur_data.next_ptr_val;
      add_empty_ptr_en_o        = 1'b0;
      add_empty_ptr_o           = cur_addr;
      head_wr_en_o              = 1'b0;
      head_wr_addr_o            = task_locked.bucket;
      head_wr_data_ptr_o        = cur_data.next_ptr;
      head_wr_data_ptr_val_o    = cur_data.next_ptr_val;
      result_valid_o            = 1'b0;
      result_o.key              = task_locked.key;
      result_o.cmd              = task_locked.cmd;
      result_o.value            = task_locked.value;
      result_o.res              = DELETE_NOT_SUCCESS_NO_ENTRY;
      case (state)
         IDLE_S: begin
            if (task_accept) state_next = task_i.head_ptr_val ? READ_HEAD_S : NOT_FOUND_S;
         end
         READ_HEAD_S, GO_ON_CHAIN_S: begin
            if (rd_data_val) begin
               if (key_match)  state_next = (state == READ_HEAD_S) ? IN_HEAD_S : IN_MIDDLE_S;
               else if (tail) state_next = NOT_FOUND_S;
               else           state_next = GO_ON_CHAIN_S;
            end
         end
         IN_HEAD_S: begin
            head_wr_en_o       = 1'b1;
            add_empty_ptr_en_o = 1'b1;
            state_next         = DONE_S;
         end
         IN_MIDDLE_S: begin
            wr_en_o            = 1'b1;
            add_empty_ptr_en_o = 1'b1;
            state_next         = DONE_S;
         end
         DONE_S: begin
            result_valid_o = 1'b1;
            result_o.res   = DELETE_SUCCESS;
            result_o.value = cur_data.value;
            if (result_ready_i) state_next = IDLE_S;
         end
         NOT_FOUND_S: begin
            result_valid_o = 1'b1;
            if (result_ready_i) state_next = IDLE_S;
         end
         default: state_next = IDLE_S;
      endcase
   end

endmodule
